store_buffer: RTL and testbench

//  Posted-write FIFO between the core's load/store path and data memory. Retires

---
 rtl/store_buffer_if.sv | 44 ++++
 rtl/store_buffer.sv | 114 +++++++++++
 tb/tb_store_buffer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store buffer port bundle: core store/load request path plus the data-memory port.
//   master : environment side (core + data memory) - drives store/load requests and
//            memory read data, observes readiness, forwarding result and memory port.
//   slave  : store buffer side.
// Ports: st_valid/st_addr/st_data/st_ready, ld_req/ld_addr/ld_hit/ld_data,
//        mem_read_data/mem_address/mem_write_data/mem_write/mem_read, empty, count.
interface store_buffer_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;

  logic [DATA_W-1:0] mem_read_data;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write;
  logic              mem_read;

  logic              empty;
  logic [CNT_W-1:0]  count;

  modport master (
    output st_valid, st_addr, st_data, ld_req, ld_addr, mem_read_data,
    input  st_ready, ld_hit, ld_data, mem_address, mem_write_data, mem_write,
           mem_read, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_req, ld_addr, mem_read_data,
    output st_ready, ld_hit, ld_data, mem_address, mem_write_data, mem_write,
           mem_read, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core load/store path and data memory.
// Stores retire into a DEPTH-entry FIFO in one cycle and drain one per cycle onto
// the memory port whenever no missing load needs it. Loads matching a buffered
// entry are forwarded from the youngest match; others read memory directly.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   sb (slave) : store request/ready, load request/hit/data, memory port, empty, count
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  store_buffer_if.slave sb
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              empty_c;
  logic              full_c;
  logic              mem_read_c;
  logic              drain_c;
  logic              push_c;

  // Forwarding: walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[head_q + PTR_W'(i)] && (addr_q[head_q + PTR_W'(i)] == sb.ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head_q + PTR_W'(i)];
      end
    end
  end

  // Port arbitration: a missing load owns the memory port, otherwise drain the head.
  always_comb begin
    empty_c    = (count_q == '0);
    full_c     = (count_q == CNT_W'(DEPTH));
    mem_read_c = sb.ld_req & ~fwd_hit;
    drain_c    = ~empty_c & ~mem_read_c;
    // A drain on this edge frees the head slot, so a full buffer still accepts.
    push_c     = sb.st_valid & (~full_c | drain_c);
  end

  assign sb.st_ready      = ~full_c | drain_c;
  assign sb.ld_hit        = sb.ld_req & fwd_hit;
  assign sb.ld_data       = (sb.ld_req & fwd_hit) ? fwd_data : sb.mem_read_data;
  assign sb.mem_read      = mem_read_c;
  assign sb.mem_write     = drain_c;
  assign sb.mem_address   = mem_read_c ? sb.ld_addr : addr_q[head_q];
  assign sb.mem_write_data = data_q[head_q];
  assign sb.empty         = empty_c;
  assign sb.count         = count_q;

  // Next state: drain retires the head, push writes the tail (push wins on a shared slot).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (drain_c) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push_c) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = sb.st_addr;
      data_d[tail_q]  = sb.st_data;
      tail_d          = tail_q + PTR_W'(1);
    end
    case ({push_c, drain_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payloads are qualified by valid bits and need no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed vector table, hand-written corner sequences
// (full push+drain across pointer wrap, asynchronous reset mid-drain) and random
// traffic, all compared against a queue-based reference model.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) sb_if ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
  } ent_t;

  ent_t        q[$];
  logic [63:0] wlog[$];
  int          total = 0;
  int          bad   = 0;

  logic        o_hit, o_rd, o_wr, o_rdy;
  logic [63:0] o_ldd, o_addr, o_wdata;
  int          o_cnt;

  typedef struct {
    logic        sv;
    logic [63:0] sa, sd;
    logic        lr;
    logic [63:0] la, mrd;
    logic        hit;
    logic [63:0] ldd;
    logic        rd, wr;
    logic [63:0] addr, wdata;
    int          cnt;
    logic        rdy;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, compare against model mid-cycle, clock, update model.
  task automatic step(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                      input logic lr, input logic [63:0] la, input logic [63:0] mrd);
    logic        hit, e_hit, e_rd, e_wr, e_rdy;
    logic [63:0] hd, e_ldd;
    sb_if.st_valid      = sv;
    sb_if.st_addr       = sa;
    sb_if.st_data       = sd;
    sb_if.ld_req        = lr;
    sb_if.ld_addr       = la;
    sb_if.mem_read_data = mrd;
    #3;
    hit = 1'b0;
    hd  = '0;
    foreach (q[i]) if (q[i].a == la) begin hit = 1'b1; hd = q[i].d; end
    e_hit = lr && hit;
    e_ldd = e_hit ? hd : mrd;
    e_rd  = lr && !hit;
    e_wr  = (q.size() != 0) && !e_rd;
    e_rdy = (q.size() < DEPTH) || e_wr;
    o_hit = sb_if.ld_hit;  o_ldd = sb_if.ld_data;  o_rd = sb_if.mem_read;
    o_wr  = sb_if.mem_write; o_addr = sb_if.mem_address; o_wdata = sb_if.mem_write_data;
    o_cnt = int'(sb_if.count); o_rdy = sb_if.st_ready;
    chk("m_ld_hit", 64'(o_hit), 64'(e_hit));
    chk("m_ld_data", o_ldd, e_ldd);
    chk("m_mem_read", 64'(o_rd), 64'(e_rd));
    chk("m_mem_write", 64'(o_wr), 64'(e_wr));
    chk("m_st_ready", 64'(o_rdy), 64'(e_rdy));
    chk("m_count", 64'(o_cnt), 64'(q.size()));
    chk("m_empty", 64'(sb_if.empty), 64'(q.size() == 0));
    if (e_rd) chk("m_rd_addr", o_addr, la);
    if (e_wr) begin
      chk("m_wr_addr", o_addr, q[0].a);
      chk("m_wr_data", o_wdata, q[0].d);
    end
    @(posedge clk);
    if (e_wr) begin
      wlog.push_back(q[0].a);
      void'(q.pop_front());
    end
    if (sv && e_rdy) q.push_back('{a: sa, d: sd});
    #1;
  endtask

  task automatic vset(input int i, input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                      input logic lr, input logic [63:0] la, input logic [63:0] mrd,
                      input logic hit, input logic [63:0] ldd, input logic rd, input logic wr,
                      input logic [63:0] addr, input logic [63:0] wdata, input int cnt,
                      input logic rdy);
    vecs[i] = '{sv, sa, sd, lr, la, mrd, hit, ldd, rd, wr, addr, wdata, cnt, rdy};
  endtask

  initial begin
    //    i   sv sa     sd      lr la     mrd      hit ldd     rd wr addr   wdata   cnt rdy
    vset(0,  1, 'h10, 'hAA,  0, 0,     0,       0, 0,      0, 0, 0,     0,      0, 1);
    vset(1,  0, 0,    0,     0, 0,     0,       0, 0,      0, 1, 'h10,  'hAA,   1, 1);
    vset(2,  0, 0,    0,     0, 0,     0,       0, 0,      0, 0, 0,     0,      0, 1);
    vset(3,  1, 'h1,  'h101, 1, 'h80,  'h5555,  0, 'h5555, 1, 0, 'h80,  0,      0, 1);
    vset(4,  1, 'h2,  'h102, 1, 'h80,  'h5555,  0, 'h5555, 1, 0, 'h80,  0,      1, 1);
    vset(5,  1, 'h3,  'h103, 1, 'h80,  'h5555,  0, 'h5555, 1, 0, 'h80,  0,      2, 1);
    vset(6,  1, 'h4,  'h104, 1, 'h80,  'h5555,  0, 'h5555, 1, 0, 'h80,  0,      3, 1);
    vset(7,  1, 'h5,  'h105, 1, 'h80,  'h5555,  0, 'h5555, 1, 0, 'h80,  0,      4, 0);
    vset(8,  0, 0,    0,     0, 0,     0,       0, 0,      0, 1, 'h1,   'h101,  4, 1);
    vset(9,  0, 0,    0,     0, 0,     0,       0, 0,      0, 1, 'h2,   'h102,  3, 1);
    vset(10, 0, 0,    0,     0, 0,     0,       0, 0,      0, 1, 'h3,   'h103,  2, 1);
    vset(11, 0, 0,    0,     0, 0,     0,       0, 0,      0, 1, 'h4,   'h104,  1, 1);
    vset(12, 1, 'h20, 'h11,  1, 'h80,  'h5555,  0, 'h5555, 1, 0, 'h80,  0,      0, 1);
    vset(13, 1, 'h20, 'h22,  1, 'h80,  'h5555,  0, 'h5555, 1, 0, 'h80,  0,      1, 1);
    vset(14, 0, 0,    0,     1, 'h20,  'h5555,  1, 'h22,   0, 1, 'h20,  'h11,   2, 1);
    vset(15, 0, 0,    0,     1, 'h20,  'h5555,  1, 'h22,   0, 1, 'h20,  'h22,   1, 1);
    vset(16, 0, 0,    0,     1, 'h20,  'h77,    0, 'h77,   1, 0, 'h20,  0,      0, 1);
    vset(17, 0, 0,    0,     1, 'h40,  'h1234,  0, 'h1234, 1, 0, 'h40,  0,      0, 1);

    sb_if.st_valid = 1'b0; sb_if.st_addr = '0; sb_if.st_data = '0;
    sb_if.ld_req = 1'b1;   sb_if.ld_addr = 'h80; sb_if.mem_read_data = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with a load pending so mem_read must follow ld_req.
    chk("rst_st_ready", 64'(sb_if.st_ready), 64'd1);
    chk("rst_empty", 64'(sb_if.empty), 64'd1);
    chk("rst_count", 64'(sb_if.count), 64'd0);
    chk("rst_mem_write", 64'(sb_if.mem_write), 64'd0);
    chk("rst_mem_read", 64'(sb_if.mem_read), 64'd1);
    sb_if.ld_req = 1'b0;
    #1;
    chk("rst_mem_read_idle", 64'(sb_if.mem_read), 64'd0);
    rst = 1'b0;

    // Directed vector table.
    foreach (vecs[i]) begin
      step(vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].lr, vecs[i].la, vecs[i].mrd);
      chk($sformatf("v%0d_ld_hit", i), 64'(o_hit), 64'(vecs[i].hit));
      chk($sformatf("v%0d_ld_data", i), o_ldd, vecs[i].ldd);
      chk($sformatf("v%0d_mem_read", i), 64'(o_rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d_mem_write", i), 64'(o_wr), 64'(vecs[i].wr));
      chk($sformatf("v%0d_count", i), 64'(o_cnt), 64'(vecs[i].cnt));
      chk($sformatf("v%0d_st_ready", i), 64'(o_rdy), 64'(vecs[i].rdy));
      if (vecs[i].rd || vecs[i].wr) chk($sformatf("v%0d_mem_addr", i), o_addr, vecs[i].addr);
      if (vecs[i].wr) chk($sformatf("v%0d_wr_data", i), o_wdata, vecs[i].wdata);
    end

    // Full buffer with drain and push together, across the pointer wrap.
    wlog.delete();
    for (int i = 0; i < 4; i++) step(1, 64'('h100 + i), 64'('hD00 + i), 1, 'h80, 0);
    for (int i = 4; i < 8; i++) begin
      step(1, 64'('h100 + i), 64'('hD00 + i), 0, 0, 0);
      chk("full_push_ready", 64'(o_rdy), 64'd1);
      chk("full_push_count", 64'(o_cnt), 64'd4);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    chk("wrap_drain_cnt", 64'(wlog.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < wlog.size()) chk("wrap_drain_order", wlog[i], 64'('h100 + i));
      else chk("wrap_drain_missing", 64'(i), 64'(wlog.size()));
    end
    chk("wrap_empty", 64'(sb_if.empty), 64'd1);

    // Asynchronous reset mid-drain with three entries buffered.
    for (int i = 0; i < 3; i++) step(1, 64'('h200 + i), 64'('hE00 + i), 1, 'h80, 0);
    sb_if.st_valid = 1'b0;
    sb_if.ld_req   = 1'b0;
    #1;
    chk("pre_rst_write", 64'(sb_if.mem_write), 64'd1);
    chk("pre_rst_count", 64'(sb_if.count), 64'd3);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_write", 64'(sb_if.mem_write), 64'd0);
    chk("async_rst_empty", 64'(sb_if.empty), 64'd1);
    chk("async_rst_count", 64'(sb_if.count), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    step(0, 0, 0, 1, 'h201, 'h9);
    chk("post_rst_miss", 64'(o_hit), 64'd0);
    chk("post_rst_ld_data", o_ldd, 64'h9);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic sv, lr;
      sv = ($urandom_range(0, 99) < 45);
      lr = ($urandom_range(0, 99) < 40);
      if (sv && lr && ($urandom_range(0, 9) != 0)) lr = 1'b0;
      step(sv, 64'($urandom_range(0, 7)), {32'($urandom), 32'($urandom)},
           lr, 64'($urandom_range(0, 9)), {32'($urandom), 32'($urandom)});
    end
    for (int n = 0; n < 8; n++) step(0, 0, 0, 0, 0, 0);
    chk("final_empty", 64'(sb_if.empty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
